// File: rtl/ear_decimator.sv
// 1-bit oversampled stream to 8-bit PCM: two-flop synchronizer, second-order CIC decimator
// with saturation, and a hysteresis comparator that produces the tape/ULA EAR logic level.
module ear_decimator #(
    parameter int DECIM_LOG2 = 6,
    parameter int HI         = 160,
    parameter int LO         = 96
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       di,
    output logic [7:0] pcm,
    output logic       strobe,
    output logic       level
);

    localparam int W     = 2 * DECIM_LOG2 + 1;
    localparam int SHIFT = 2 * DECIM_LOG2 - 8;
    localparam logic [7:0] HI_TH = HI[7:0];
    localparam logic [7:0] LO_TH = LO[7:0];

    logic                  r_sync1;
    logic                  r_sync2;
    logic [DECIM_LOG2-1:0] r_cnt;
    logic [W-1:0]          r_int1;
    logic [W-1:0]          r_int2;
    logic [W-1:0]          r_d1;
    logic [W-1:0]          r_d2;
    logic [7:0]            r_pcm;
    logic                  r_strobe;
    logic                  r_level;

    logic                  w_last;
    logic [W-1:0]          w_c1;
    logic [W-1:0]          w_c2;
    logic [W-1:0]          w_shifted;
    logic [7:0]            w_sat;
    logic                  w_level_next;

    // The comb stage runs once per period on the last count; all arithmetic wraps modulo 2^W.
    always_comb begin
        w_last       = &r_cnt;
        w_c1         = r_int2 - r_d1;
        w_c2         = w_c1 - r_d2;
        w_shifted    = w_c2 >> SHIFT;
        w_sat        = (w_shifted > W'(255)) ? 8'hFF : w_shifted[7:0];
        w_level_next = r_level;
        if (w_sat >= HI_TH) begin
            w_level_next = 1'b1;
        end else if (w_sat <= LO_TH) begin
            w_level_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_int1   <= '0;
            r_int2   <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_pcm    <= 8'd0;
            r_strobe <= 1'b0;
            r_level  <= 1'b0;
        end else begin
            r_sync1  <= di;
            r_sync2  <= r_sync1;
            r_cnt    <= r_cnt + 1'b1;
            r_int1   <= r_int1 + {{(W-1){1'b0}}, r_sync2};
            r_int2   <= r_int2 + r_int1;
            r_strobe <= w_last;
            if (w_last) begin
                r_d1    <= r_int2;
                r_d2    <= w_c1;
                r_pcm   <= w_sat;
                r_level <= w_level_next;
            end
        end
    end

    assign pcm    = r_pcm;
    assign strobe = r_strobe;
    assign level  = r_level;

endmodule

// File: tb/tb_ear_decimator.sv
// Directed bench for ear_decimator: expected samples are queued per phase and
// popped on each strobe; strobe timing is checked on every cycle.
module tb_ear_decimator;

    localparam int R = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       di = 1'b0;
    logic [7:0] pcm;
    logic       strobe;
    logic       level;

    typedef struct {
        int         kind;   // 0 = fill transient, 1 = exact value, 2 = hysteresis transition
        logic [7:0] pcm;
        logic       lvl;
    } exp_t;

    exp_t sb[$];
    int   nAssert = 0;
    int   nFail = 0;
    int   cyc = 0;
    int   patPhase = 0;
    logic modelLevel = 1'b0;

    always #5 clock = ~clock;

    ear_decimator #(.DECIM_LOG2(6), .HI(160), .LO(96)) dut (
        .clock (clock),
        .reset (reset),
        .di    (di),
        .pcm   (pcm),
        .strobe(strobe),
        .level (level)
    );

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input logic [7:0] p, input logic l, input int count);
        exp_t e;
        e.kind = kind;
        e.pcm  = p;
        e.lvl  = l;
        for (int i = 0; i < count; i++) sb.push_back(e);
    endtask

    task automatic checkEmpty(input string tag);
        nAssert++;
        assert (sb.size() == 0) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d strobes still pending, expected 0", tag, sb.size());
        end
    endtask

    // Called at the falling edge after every rising edge, away from the sampling edge.
    task automatic checkOutput();
        exp_t e;
        logic expStrobe;
        logic expLevel;
        expStrobe = (cyc != 0) && (cyc % R == 0);
        expectEq("strobe", {31'd0, strobe}, {31'd0, expStrobe});
        if (strobe === 1'b1) begin
            nAssert++;
            assert (sb.size() > 0) else begin
                nFail++;
                $error("[TB] FAIL unexpectedStrobe: observed strobe with %0d queued, expected queued > 0", sb.size());
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.kind == 1) begin
                    expectEq("pcm", {24'd0, pcm}, {24'd0, e.pcm});
                    expectEq("level", {31'd0, level}, {31'd0, e.lvl});
                    modelLevel = e.lvl;
                end else if (e.kind == 2) begin
                    expLevel = (pcm >= 8'd160) ? 1'b1 : ((pcm <= 8'd96) ? 1'b0 : modelLevel);
                    expectEq("levelHyst", {31'd0, level}, {31'd0, expLevel});
                    modelLevel = expLevel;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic diVal, input logic rstVal);
        di    = diVal;
        reset = rstVal;
        @(posedge clock);
        if (rstVal) cyc = 0;
        else        cyc = cyc + 1;
        @(negedge clock);
        checkOutput();
    endtask

    task automatic doReset(input int n);
        sb.delete();
        patPhase   = 0;
        modelLevel = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1);
            expectEq("resetPcm", {24'd0, pcm}, 32'd0);
            expectEq("resetStrobe", {31'd0, strobe}, 32'd0);
            expectEq("resetLevel", {31'd0, level}, 32'd0);
        end
    endtask

    task automatic runPattern(input logic [3:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(pat[patPhase % 4], 1'b0);
            patPhase++;
        end
    endtask

    initial begin
        // Constant one: saturates to 255 and sets level once the filter has filled.
        doReset(3);
        pushExp(0, 8'd0, 1'b0, 2);
        pushExp(1, 8'd255, 1'b1, 4);
        runPattern(4'b1111, 6 * R);
        checkEmpty("ones");

        // Constant zero: every sample is exactly zero, including the fill strobes.
        doReset(3);
        pushExp(1, 8'd0, 1'b0, 4);
        runPattern(4'b0000, 4 * R);
        checkEmpty("zeros");

        // 50% density lands between the thresholds, so level never leaves 0.
        doReset(3);
        pushExp(0, 8'd0, 1'b0, 2);
        pushExp(1, 8'd128, 1'b0, 4);
        runPattern(4'b0101, 6 * R);
        checkEmpty("alternating");

        // 75% then 25%: level must follow hysteresis through the transition sample.
        doReset(3);
        pushExp(0, 8'd0, 1'b0, 2);
        pushExp(1, 8'd192, 1'b1, 6);
        runPattern(4'b0111, 8 * R);
        checkEmpty("dense");
        pushExp(2, 8'd0, 1'b0, 1);
        pushExp(1, 8'd64, 1'b0, 5);
        runPattern(4'b0001, 6 * R);
        checkEmpty("sparse");

        // Reset one cycle at cnt = 37 discards the partial period.
        doReset(3);
        pushExp(0, 8'd0, 1'b0, 1);
        runPattern(4'b1111, 101);
        checkEmpty("preReset");
        doReset(1);
        pushExp(0, 8'd0, 1'b0, 1);
        runPattern(4'b1111, R);
        checkEmpty("postReset");

        // Long run so both integrators wrap many times.
        doReset(3);
        pushExp(0, 8'd0, 1'b0, 2);
        pushExp(1, 8'd255, 1'b1, 998);
        runPattern(4'b1111, 1000 * R);
        checkEmpty("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
